mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Two-master arbiter that shares the single memory_bus port (ROM, RAM, peripherals) between the CPU core (master 0) and an auxiliary master (master 1), such as a UART program loader or DMA engine. Each master uses a req/ack handshake and holds its request until acknowledged. The arbiter registers the winner's request onto the bus for a fixed access window, captures read data, and pulses ack. Masters alternate round-robin when both request at once.

Parameters:
ACCESS_CYCLES, 2, number of clk cycles bus_enable is held per transaction (min 1; covers memory_bus read latency)
ADDR_WIDTH, 16, bus address width
DATA_WIDTH, 32, bus data width

Ports:
clk  input  1  arbiter clock, same domain as the memory bus
reset  input  1  asynchronous active-high reset
m0_req  input  1  CPU request; held until m0_ack
m0_we  input  1  CPU write (1) / read (0)
m0_address  input  ADDR_WIDTH  CPU byte address
m0_wdata  input  DATA_WIDTH  CPU write data
m0_write_mask  input  4  CPU byte mask; bit=0 means the byte is written
m0_ack  output  1  one-cycle completion pulse to CPU
m0_rdata  output  DATA_WIDTH  CPU read data, valid while m0_ack is high and held afterwards
m1_req, m1_we, m1_address, m1_wdata, m1_write_mask, m1_ack, m1_rdata  same as m0_*, for the aux master
grant  output  2  one-hot owner of the current transaction (00 when idle)
bus_address  output  ADDR_WIDTH  to memory_bus address
bus_data_in  output  DATA_WIDTH  to memory_bus data_in
bus_write_mask  output  4  to memory_bus write_mask
bus_enable  output  1  to memory_bus bus_enable
bus_write_enable  output  1  to memory_bus write_enable
bus_data_out  input  DATA_WIDTH  from memory_bus data_out

Behaviour:
- Reset is async and active-high. Reset values: all bus_* outputs 0, bus_write_mask 4'b1111 (no bytes written), m0_ack/m1_ack 0, m0_rdata/m1_rdata 0, grant 00, state IDLE, last_grant = 1 (m0 wins the first tie).
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that master.
  - Both req: grant the master that is not last_grant.
  - On grant: register the winner's address/wdata/mask/we onto bus_*; bus_enable=1; bus_write_enable=we; grant one-hot; last_grant=winner; count=ACCESS_CYCLES-1; go to ACCESS.
- ACCESS: bus_* held stable. While count!=0, decrement count. When count==0, at that edge:
  - Read: capture bus_data_out into the winner's rdata.
  - bus_enable=0, bus_write_enable=0, bus_write_mask=4'b1111.
  - Winner's ack=1; go to DONE.
- DONE: ack stays high this cycle only. Next edge: ack=0, grant=00, go to IDLE.
- Handshake rule: a master deasserts req, or presents a new request, on the edge where it samples ack=1. Because DONE always passes through IDLE, a stale req is never re-granted.
- Latency: req sampled at edge E → bus_enable high from E to E+ACCESS_CYCLES → ack high for the cycle after E+ACCESS_CYCLES. Earliest next grant is at edge E+ACCESS_CYCLES+2.
- Writes do not change rdata.
- Losing master's inputs are ignored; its req stays pending and wins the next arbitration.
- req dropped mid-ACCESS: the transaction completes and ack still pulses.
- Requester inputs changing mid-ACCESS have no effect; bus_* come only from registers.
- Reset mid-ACCESS: bus_enable and bus_write_enable drop immediately with no ack, and the transaction is lost.
- No address decoding, no error response, no locked transfers.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE=0, ACCESS=1, DONE=2), MASTER_CPU=0, MASTER_AUX=1, MASK_NONE=4'b1111.
- One sub-module, arb_rr2: holds the last_grant register and produces the one-hot winner from the two reqs plus an update strobe.
- The main module holds the FSM, counter and data registers.

Test Plan:
- Reset, then m0 read at 0x4000 with bus_data_out=0x12345678, ACCESS_CYCLES=2 → bus_enable high 2 cycles, m0_ack pulses 1 cycle, m0_rdata=0x12345678, grant=01, m1_ack never asserts.
- m1 byte write at 0x0103, wdata=0x000000AB, mask=4'b0111 → bus_write_enable=1, bus_write_mask=0111, bus_data_in=0x000000AB, m1_ack pulse, m1_rdata unchanged.
- m0 and m1 both request continuously for 4 transactions → grants m0, m1, m0, m1; each ack arrives 4 cycles after the previous.
- m0 alone issues back-to-back reads, changing address on the ack edge → no duplicate transaction; second grant at E+ACCESS_CYCLES+2.
- Reset asserted one cycle into ACCESS → bus_enable=0 asynchronously, no ack; after release, a pending m1 req is granted first (last_grant reset to 1 → m0 only wins ties).
- ACCESS_CYCLES=1: m0 read → bus_enable high exactly 1 cycle, ack on the next cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam int MASTER_CPU = 0;
    localparam int MASTER_AUX = 1;

    // Write mask polarity is active-low: all ones means no byte is written.
    localparam logic [3:0] MASK_NONE = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes plus the memory_bus side of the arbiter, bundled as one interface.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_address;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [3:0]            m0_write_mask;
    logic                  m0_ack;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_address;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [3:0]            m1_write_mask;
    logic                  m1_ack;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic [DATA_WIDTH-1:0] bus_data_in;
    logic [3:0]            bus_write_mask;
    logic                  bus_enable;
    logic                  bus_write_enable;
    logic [DATA_WIDTH-1:0] bus_data_out;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_we, m0_address, m0_wdata, m0_write_mask,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_address, m1_wdata, m1_write_mask,
        output m1_ack, m1_rdata,
        output grant, bus_address, bus_data_in, bus_write_mask,
        output bus_enable, bus_write_enable,
        input  bus_data_out
    );

    // Requesters and memory side.
    modport master (
        output m0_req, m0_we, m0_address, m0_wdata, m0_write_mask,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_address, m1_wdata, m1_write_mask,
        input  m1_ack, m1_rdata,
        input  grant, bus_address, bus_data_in, bus_write_mask,
        input  bus_enable, bus_write_enable,
        output bus_data_out
    );

endinterface

// File: rtl/mem_bus_arbiter_rr2.sv
// Two-way round-robin picker: one-hot winner from the requests, remembers the last winner.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] winner_o
);

    // 1 means the aux master won last, so the CPU takes the first tie after reset.
    logic last_grant_q;

    // A lone request wins outright; a tie goes to whoever did not win last time.
    always_comb begin
        winner_o = req_i;
        if (req_i == 2'b11) begin
            winner_o = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    // Record the winner only when a grant is actually taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (update_i && (winner_o != 2'b00)) begin
            last_grant_q <= winner_o[MASTER_AUX];
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory_bus between the CPU (master 0) and an aux master (master 1).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic        clk,
    input  logic        reset,
    mem_bus_arbiter_if.slave bif
);

    localparam int                CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t            state_q;
    logic [CNT_W-1:0]      count_q;
    logic [1:0]            grant_q;
    logic [ADDR_WIDTH-1:0] bus_address_q;
    logic [DATA_WIDTH-1:0] bus_data_in_q;
    logic [3:0]            bus_write_mask_q;
    logic                  bus_enable_q;
    logic                  bus_write_enable_q;
    logic                  m0_ack_q;
    logic                  m1_ack_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q;
    logic [DATA_WIDTH-1:0] m1_rdata_q;

    logic [1:0]            req;
    logic [1:0]            winner;
    logic                  arb_update;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [3:0]            mask_d;
    logic                  we_d;

    assign req        = {bif.m1_req, bif.m0_req};
    assign arb_update = (state_q == IDLE);

    arb_rr2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .update_i (arb_update),
        .winner_o (winner)
    );

    // Only the winner's request fields reach the bus registers.
    assign addr_d  = winner[MASTER_AUX] ? bif.m1_address    : bif.m0_address;
    assign wdata_d = winner[MASTER_AUX] ? bif.m1_wdata      : bif.m0_wdata;
    assign mask_d  = winner[MASTER_AUX] ? bif.m1_write_mask : bif.m0_write_mask;
    assign we_d    = winner[MASTER_AUX] ? bif.m1_we         : bif.m0_we;

    // Grant, hold the bus for the access window, then ack for one cycle and return through IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            count_q            <= '0;
            grant_q            <= 2'b00;
            bus_address_q      <= '0;
            bus_data_in_q      <= '0;
            bus_write_mask_q   <= MASK_NONE;
            bus_enable_q       <= 1'b0;
            bus_write_enable_q <= 1'b0;
            m0_ack_q           <= 1'b0;
            m1_ack_q           <= 1'b0;
            m0_rdata_q         <= '0;
            m1_rdata_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winner != 2'b00) begin
                        bus_address_q      <= addr_d;
                        bus_data_in_q      <= wdata_d;
                        bus_write_mask_q   <= mask_d;
                        bus_enable_q       <= 1'b1;
                        bus_write_enable_q <= we_d;
                        grant_q            <= winner;
                        count_q            <= CNT_LOAD;
                        state_q            <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count_q != '0) begin
                        count_q <= count_q - CNT_W'(1);
                    end else begin
                        if (!bus_write_enable_q) begin
                            if (grant_q[MASTER_CPU]) m0_rdata_q <= bif.bus_data_out;
                            if (grant_q[MASTER_AUX]) m1_rdata_q <= bif.bus_data_out;
                        end
                        bus_enable_q       <= 1'b0;
                        bus_write_enable_q <= 1'b0;
                        bus_write_mask_q   <= MASK_NONE;
                        m0_ack_q           <= grant_q[MASTER_CPU];
                        m1_ack_q           <= grant_q[MASTER_AUX];
                        state_q            <= DONE;
                    end
                end
                DONE: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    grant_q  <= 2'b00;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bif.m0_ack           = m0_ack_q;
    assign bif.m1_ack           = m1_ack_q;
    assign bif.m0_rdata         = m0_rdata_q;
    assign bif.m1_rdata         = m1_rdata_q;
    assign bif.grant            = grant_q;
    assign bif.bus_address      = bus_address_q;
    assign bif.bus_data_in      = bus_data_in_q;
    assign bif.bus_write_mask   = bus_write_mask_q;
    assign bif.bus_enable       = bus_enable_q;
    assign bif.bus_write_enable = bus_write_enable_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: edge-indexed transaction model plus directed scenarios.
module tb_mem_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int AC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    mem_bus_arbiter #(.ACCESS_CYCLES(AC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bif   (ifa.slave)
    );

    mem_bus_arbiter #(.ACCESS_CYCLES(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bif   (ifb.slave)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction model for dut_a ----------------
    // A grant taken at posedge number E owns the bus for posedges E..E+AC-1,
    // acks after posedge E+AC, and the next grant is possible at E+AC+2.
    int              cyc = 0;
    int              t_start = -100;
    int              t_free = 0;
    int              owner = 0;
    bit              last_aux = 1'b1;
    logic            owner_we = 1'b0;
    logic [AW-1:0]   owner_addr = '0;
    logic [DW-1:0]   owner_wdata = '0;
    logic [3:0]      owner_mask = 4'hF;
    logic [DW-1:0]   exp_rd [2] = '{default: '0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t_start   = -100;
            t_free    = 0;
            last_aux  = 1'b1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else begin
            cyc++;
            if (cyc == t_start + AC && !owner_we) exp_rd[owner] = ifa.bus_data_out;
            if (cyc >= t_free && (ifa.m0_req || ifa.m1_req)) begin
                if (ifa.m0_req && ifa.m1_req) owner = last_aux ? 0 : 1;
                else                          owner = ifa.m1_req ? 1 : 0;
                last_aux    = (owner == 1);
                owner_we    = owner ? ifa.m1_we         : ifa.m0_we;
                owner_addr  = owner ? ifa.m1_address    : ifa.m0_address;
                owner_wdata = owner ? ifa.m1_wdata      : ifa.m0_wdata;
                owner_mask  = owner ? ifa.m1_write_mask : ifa.m0_write_mask;
                t_start     = cyc;
                t_free      = cyc + AC + 2;
            end
        end
    end

    // Every cycle, compare all dut_a outputs with what the model says they must be.
    always @(negedge clk) begin : cmp
        int         k;
        logic       e_en, e_we, e_ack0, e_ack1;
        logic [3:0] e_mask;
        logic [1:0] e_grant;
        k       = cyc - t_start;
        e_en    = 1'b0;
        e_we    = 1'b0;
        e_mask  = 4'hF;
        e_grant = 2'b00;
        e_ack0  = 1'b0;
        e_ack1  = 1'b0;
        if (k >= 0 && k < AC) begin
            e_en    = 1'b1;
            e_we    = owner_we;
            e_mask  = owner_mask;
            e_grant = (owner == 1) ? 2'b10 : 2'b01;
        end else if (k == AC) begin
            e_grant = (owner == 1) ? 2'b10 : 2'b01;
            e_ack0  = (owner == 0);
            e_ack1  = (owner == 1);
        end
        chk("bus_enable", ifa.bus_enable, e_en);
        chk("bus_write_enable", ifa.bus_write_enable, e_we);
        chk("bus_write_mask", ifa.bus_write_mask, e_mask);
        chk("grant", ifa.grant, e_grant);
        chk("m0_ack", ifa.m0_ack, e_ack0);
        chk("m1_ack", ifa.m1_ack, e_ack1);
        chk("m0_rdata", ifa.m0_rdata, exp_rd[0]);
        chk("m1_rdata", ifa.m1_rdata, exp_rd[1]);
        if (e_en) begin
            chk("bus_address", ifa.bus_address, owner_addr);
            chk("bus_data_in", ifa.bus_data_in, owner_wdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_m(input int m, input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [3:0] mk);
        if (m == 0) begin
            ifa.m0_req = req; ifa.m0_we = we; ifa.m0_address = a; ifa.m0_wdata = d; ifa.m0_write_mask = mk;
        end else begin
            ifa.m1_req = req; ifa.m1_we = we; ifa.m1_address = a; ifa.m1_wdata = d; ifa.m1_write_mask = mk;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge where the ack is seen (or the budget runs out).
    task automatic wait_ack(input int m, input int budget, output int waited, output int en_cycles);
        logic a;
        waited    = 0;
        en_cycles = 0;
        do begin
            @(negedge clk);
            waited++;
            if (ifa.bus_enable) en_cycles++;
            a = (m == 0) ? ifa.m0_ack : ifa.m1_ack;
        end while (a !== 1'b1 && waited < budget);
        if (a !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout_m%0d waited=%0d expected ack within %0d", m, waited, budget);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : seq
        int w, en, t1, t2, who;
        int order [4];
        int tack [4];
        int ndone [2];

        drive_m(0, 1'b0, 1'b0, '0, '0, 4'hF);
        drive_m(1, 1'b0, 1'b0, '0, '0, 4'hF);
        ifa.bus_data_out = '0;
        ifb.m0_req = 1'b0; ifb.m0_we = 1'b0; ifb.m0_address = '0; ifb.m0_wdata = '0; ifb.m0_write_mask = 4'hF;
        ifb.m1_req = 1'b0; ifb.m1_we = 1'b0; ifb.m1_address = '0; ifb.m1_wdata = '0; ifb.m1_write_mask = 4'hF;
        ifb.bus_data_out = '0;

        idle(2);
        reset = 1'b0;
        chk("rst_mask", ifa.bus_write_mask, 4'b1111);
        chk("rst_grant", ifa.grant, 2'b00);
        chk("rst_enable", ifa.bus_enable, 1'b0);
        chk("rst_m0_rdata", ifa.m0_rdata, 32'h0);

        // CPU read.
        ifa.bus_data_out = 32'h12345678;
        drive_m(0, 1'b1, 1'b0, 16'h4000, 32'h0, 4'hF);
        wait_ack(0, 10, w, en);
        chk("t1_latency", w, AC + 1);
        chk("t1_enable_cycles", en, AC);
        chk("t1_grant", ifa.grant, 2'b01);
        chk("t1_m0_rdata", ifa.m0_rdata, 32'h12345678);
        chk("t1_m1_ack", ifa.m1_ack, 1'b0);
        drive_m(0, 1'b0, 1'b0, 16'h4000, 32'h0, 4'hF);
        idle(2);

        // Aux byte write.
        drive_m(1, 1'b1, 1'b1, 16'h0103, 32'h000000AB, 4'b0111);
        @(negedge clk);
        chk("t2_we", ifa.bus_write_enable, 1'b1);
        chk("t2_mask", ifa.bus_write_mask, 4'b0111);
        chk("t2_data_in", ifa.bus_data_in, 32'h000000AB);
        chk("t2_address", ifa.bus_address, 16'h0103);
        wait_ack(1, 10, w, en);
        chk("t2_m1_rdata_kept", ifa.m1_rdata, 32'h0);
        drive_m(1, 1'b0, 1'b0, 16'h0103, 32'h0, 4'hF);
        idle(2);

        // Both masters request continuously for four transactions.
        ndone = '{0, 0};
        ifa.bus_data_out = 32'hA5A50000;
        drive_m(0, 1'b1, 1'b0, 16'h1000, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b0, 16'h2000, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (ifa.m0_ack !== 1'b1 && ifa.m1_ack !== 1'b1 && w < 12);
            who      = (ifa.m1_ack === 1'b1) ? 1 : 0;
            order[i] = (w < 12) ? who : -1;
            tack[i]  = cyc;
            ndone[who]++;
            ifa.bus_data_out = ifa.bus_data_out + 32'd1;
            if (ndone[who] < 2)
                drive_m(who, 1'b1, 1'b0, AW'(16'h1000 * (who + 1) + 16'h0004), 32'h0, 4'hF);
            else
                drive_m(who, 1'b0, 1'b0, '0, 32'h0, 4'hF);
        end
        chk("t3_order0", order[0], 0);
        chk("t3_order1", order[1], 1);
        chk("t3_order2", order[2], 0);
        chk("t3_order3", order[3], 1);
        for (int i = 1; i < 4; i++) chk("t3_ack_spacing", tack[i] - tack[i-1], 4);
        idle(2);

        // CPU back-to-back reads, new address presented on the ack edge.
        ifa.bus_data_out = 32'hCAFE0001;
        drive_m(0, 1'b1, 1'b0, 16'h0010, 32'h0, 4'hF);
        wait_ack(0, 10, w, en);
        t1 = cyc;
        chk("t4_rdata_first", ifa.m0_rdata, 32'hCAFE0001);
        ifa.bus_data_out = 32'hCAFE0002;
        drive_m(0, 1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
        wait_ack(0, 10, w, en);
        t2 = cyc;
        chk("t4_ack_spacing", t2 - t1, AC + 2);
        chk("t4_rdata_second", ifa.m0_rdata, 32'hCAFE0002);
        drive_m(0, 1'b0, 1'b0, 16'h0020, 32'h0, 4'hF);
        idle(6);

        // Requester changes its inputs and drops req mid-access.
        ifa.bus_data_out = 32'h55AA55AA;
        drive_m(1, 1'b1, 1'b0, 16'h0200, 32'h0, 4'hF);
        @(negedge clk);
        drive_m(1, 1'b0, 1'b1, 16'hFFFF, 32'hDEADBEEF, 4'h0);
        @(negedge clk);
        chk("t5_addr_held", ifa.bus_address, 16'h0200);
        chk("t5_we_held", ifa.bus_write_enable, 1'b0);
        chk("t5_enable_held", ifa.bus_enable, 1'b1);
        wait_ack(1, 10, w, en);
        chk("t5_m1_rdata", ifa.m1_rdata, 32'h55AA55AA);
        idle(2);

        // Reset one cycle into the access: transaction lost, pending aux req granted after.
        ifa.bus_data_out = 32'h0BADF00D;
        drive_m(1, 1'b1, 1'b0, 16'h0300, 32'h0, 4'hF);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_enable", ifa.bus_enable, 1'b0);
        chk("t6_rst_we", ifa.bus_write_enable, 1'b0);
        chk("t6_rst_grant", ifa.grant, 2'b00);
        chk("t6_rst_ack", ifa.m1_ack, 1'b0);
        chk("t6_rst_rdata", ifa.m1_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_regrant_m1", ifa.grant, 2'b10);
        wait_ack(1, 10, w, en);
        chk("t6_m1_rdata", ifa.m1_rdata, 32'h0BADF00D);
        drive_m(1, 1'b0, 1'b0, 16'h0300, 32'h0, 4'hF);
        idle(2);

        // CPU wins last, then reset: the first tie still goes to the CPU.
        ifa.bus_data_out = 32'h00000077;
        drive_m(0, 1'b1, 1'b0, 16'h0400, 32'h0, 4'hF);
        wait_ack(0, 10, w, en);
        drive_m(0, 1'b0, 1'b0, 16'h0400, 32'h0, 4'hF);
        idle(2);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        drive_m(0, 1'b1, 1'b0, 16'h0500, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b0, 16'h0600, 32'h0, 4'hF);
        @(negedge clk);
        chk("t7_tie_after_reset", ifa.grant, 2'b01);
        wait_ack(0, 10, w, en);
        drive_m(0, 1'b0, 1'b0, '0, 32'h0, 4'hF);
        wait_ack(1, 10, w, en);
        drive_m(1, 1'b0, 1'b0, '0, 32'h0, 4'hF);
        idle(3);

        // Single-cycle access window instance.
        ifb.bus_data_out = 32'h0F0F0F0F;
        ifb.m0_address   = 16'h0044;
        ifb.m0_we        = 1'b0;
        ifb.m0_req       = 1'b1;
        w  = 0;
        en = 0;
        do begin
            @(negedge clk);
            w++;
            if (ifb.bus_enable) en++;
        end while (ifb.m0_ack !== 1'b1 && w < 10);
        chk("ac1_ack_seen", ifb.m0_ack, 1'b1);
        chk("ac1_latency", w, 2);
        chk("ac1_enable_cycles", en, 1);
        chk("ac1_rdata", ifb.m0_rdata, 32'h0F0F0F0F);
        chk("ac1_grant", ifb.grant, 2'b01);
        ifb.m0_req = 1'b0;
        @(negedge clk);
        chk("ac1_ack_drop", ifb.m0_ack, 1'b0);
        chk("ac1_grant_drop", ifb.grant, 2'b00);
        idle(3);
        chk("ac1_no_repeat", ifb.bus_enable, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
